// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input, program RAM write port and CPU hold/status
// lines between the host receiver, the program loader and the CPU.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );
    modport master (
        output in_valid, in_data, reload,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads a sync-framed, checksummed program image into the program store
// and keeps the CPU held until a valid image has been written.
module program_loader #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1023
) (
    input logic            clk,
    input logic            rst,
    program_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TNEAR = TW'(TIMEOUT - 1);
    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] count;
    logic [7:0]    acc;
    logic [TW-1:0] tmo;
    logic          accept;
    logic [7:0]    sum;

    assign bus.in_ready = state != S_RUN;
    assign bus.cpu_hold = state != S_RUN;
    assign accept       = bus.in_valid && bus.in_ready;
    assign sum          = acc + bus.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_SYNC;
            count         <= '0;
            acc           <= '0;
            tmo           <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.load_done <= 1'b0;
            bus.load_err  <= 1'b0;
        end else begin
            bus.wr_en     <= accept && state == S_LOAD;
            bus.load_done <= 1'b0;
            if (accept && state == S_LOAD) begin
                bus.wr_addr <= count;
                bus.wr_data <= bus.in_data;
            end
            case (state)
                S_SYNC: if (accept && bus.in_data == SYNC_BYTE) begin
                    state        <= S_LOAD;
                    count        <= '0;
                    acc          <= '0;
                    tmo          <= '0;
                    bus.load_err <= 1'b0;
                end
                S_LOAD, S_CHECK: begin
                    if (accept) begin
                        tmo <= '0;
                        if (state == S_LOAD) begin
                            acc   <= sum;
                            count <= count + 1'b1;
                            state <= count == LAST ? S_CHECK : S_LOAD;
                        end else begin
                            state         <= sum == '0 ? S_RUN : S_SYNC;
                            bus.load_done <= sum == '0;
                            bus.load_err  <= sum != '0;
                        end
                    end else if (tmo == TNEAR) begin
                        // counter parks at TIMEOUT and stays idle until the next frame starts
                        state        <= S_SYNC;
                        bus.load_err <= 1'b1;
                        count        <= '0;
                        tmo          <= TMAX;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_RUN: if (bus.reload) state <= S_SYNC;
                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven frames plus hand sequences; writes are checked
// against a queue of expected {addr, data} pairs filled as bytes are driven.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    logic running = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] e;

    typedef struct {
        logic [7:0] base;
        logic [7:0] bias;
        logic       ok;
    } vec_t;
    vec_t vecs[6];

    program_loader_if bus ();
    program_loader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    bad++;
                    $display("FAIL write: got addr=%0h data=%0h want addr=%0h data=%0h",
                             bus.wr_addr, bus.wr_data, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        chk("in_ready", 32'(bus.in_ready), 1);
        step;
        bus.in_valid = 1'b0;
    endtask

    task automatic rearm;
        if (running) begin
            bus.reload = 1'b1;
            step;
            bus.reload = 1'b0;
            chk("hold_after_reload", 32'(bus.cpu_hold), 1);
            running = 1'b0;
        end
    endtask

    task automatic chk_reset;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 1);
        chk("rst_load_done", 32'(bus.load_done), 0);
        chk("rst_load_err", 32'(bus.load_err), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
    endtask

    task automatic frame(input logic [7:0] base, input logic [7:0] bias, input logic ok, input int a5_at);
        logic [7:0] sum;
        logic [7:0] b;
        rearm;
        put(8'hA5);
        chk("err_clear_on_sync", 32'(bus.load_err), 0);
        chk("hold_in_load", 32'(bus.cpu_hold), 1);
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            b = (i == a5_at) ? 8'hA5 : 8'(base + i);
            sum += b;
            exp_q.push_back({4'(i), b});
            put(b);
        end
        put(8'(bias - sum));
        chk("load_done", 32'(bus.load_done), 32'(ok));
        chk("load_err", 32'(bus.load_err), 32'(!ok));
        chk("cpu_hold", 32'(bus.cpu_hold), 32'(!ok));
        running = ok;
        step;
        chk("done_is_pulse", 32'(bus.load_done), 0);
        chk("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b1};
        vecs[1] = '{8'h00, 8'h01, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1};
        vecs[3] = '{8'hF0, 8'h00, 1'b1};
        vecs[4] = '{8'h5A, 8'h80, 1'b0};
        vecs[5] = '{8'h10, 8'h00, 1'b1};
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.reload = 1'b0;
        step;
        step;
        chk_reset;
        rst = 1'b0;
        for (int v = 0; v < 6; v++)
            frame(vecs[v].base, vecs[v].bias, vecs[v].ok, -1);

        rearm;
        put(8'h3C);
        put(8'hFF);
        chk("garbage_stays_sync", 32'(bus.cpu_hold), 1);
        frame(8'h00, 8'h00, 1'b1, 3);

        rearm;
        put(8'hA5);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({4'(i), 8'(8'h20 + i)});
            put(8'(8'h20 + i));
        end
        repeat (1022) step;
        chk("tmo_not_yet", 32'(bus.load_err), 0);
        step;
        chk("tmo_err", 32'(bus.load_err), 1);
        chk("tmo_hold", 32'(bus.cpu_hold), 1);
        repeat (5) step;
        put(8'h11);
        step;
        chk("tmo_no_writes", exp_q.size(), 0);
        chk("tmo_err_sticky", 32'(bus.load_err), 1);
        frame(8'h40, 8'h00, 1'b1, -1);

        bus.in_valid = 1'b1;
        bus.in_data = 8'h33;
        repeat (3) begin
            chk("run_not_ready", 32'(bus.in_ready), 0);
            step;
        end
        bus.in_valid = 1'b0;
        chk("run_hold_low", 32'(bus.cpu_hold), 0);
        frame(8'h80, 8'h00, 1'b1, -1);

        rearm;
        put(8'hA5);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({4'(i), 8'(8'h60 + i)});
            put(8'(8'h60 + i));
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk_reset;
        bus.reload = 1'b1;
        step;
        bus.reload = 1'b0;
        chk("reload_ignored", 32'(bus.cpu_hold), 1);
        frame(8'h33, 8'h00, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
